pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
//  Elastic, parametrised pipeline-stage register, next generation of the per-stage D/E-style regs.
//  Carries a control bundle and a data bundle between any two pipeline stages with valid/ready flow control.
//  Holds a 2-entry skid buffer so that in_ready is registered and back-pressure does not create a combinational path.
//  Flush kills both entries by clearing valids and zeroing control; data is left as is.
// PARAMETERS
//  CTRL_W  16   width of control bundle (zeroed on flush/bubble)
//  DATA_W  128  width of data bundle (never cleared by flush)
//  CNT_W   32   width of statistics counters (used only with PIPE_SKID_STATS_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       synchronous reset, active low
//  flush      in   1       kill all held entries and the current input
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage can accept (= !skid_valid & !flush)
//  in_ctrl    in   CTRL_W  upstream control bundle
//  in_data    in   DATA_W  upstream data bundle
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream accepts head
//  out_ctrl   out  CTRL_W  head control; forced '0 when out_valid=0
//  out_data   out  DATA_W  head data (ungated)
//  stall_cnt  out  CNT_W   cycles with out_valid & !out_ready   [PIPE_SKID_STATS_EN only]
//  flush_cnt  out  CNT_W   cycles with flush=1                  [PIPE_SKID_STATS_EN only]
// BEHAVIOUR
//  - Clocking: one clock, clk. Reset is synchronous and active-low (rst_n). Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (rst_n=0 at posedge): state EMPTY; all ctrl/data regs '0; out_valid=0, out_ctrl=0, out_data=0, in_ready=1 next cycle; counters 0.
//  - Priority per cycle: reset > flush > handshake.
//  - States (main=head, skid=overflow):
//  - EMPTY: in_fire -> main<=in, ONE.
//  - ONE: out_fire & in_fire -> main<=in, stay ONE.
//  - ONE: out_fire only -> EMPTY.
//  - ONE: in_fire only -> skid<=in, FULL.
//  - ONE: else hold.
//  - FULL: in_ready=0.
//  - FULL: out_fire -> main<=skid, ONE.
//  - FULL: else hold.
//  - out_valid = (state != EMPTY); in_ready = (state != FULL) & !flush.
//  - Latency 1 cycle EMPTY->out_valid; sustained throughput 1 entry/cycle with out_ready=1.
//  - Ordering strictly FIFO; no entry dropped or duplicated except by flush.
//  - Flush (rst_n=1): next state EMPTY; main/skid ctrl <= '0; data regs hold; input of that cycle discarded (in_ready=0).
//  - Flush in FULL with out_ready=1: the head still counts as consumed downstream this cycle; skid is discarded.
//  - Held entries stable: out_ctrl/out_data must not change while out_valid & !out_ready.
//  - Reset asserted mid-transfer discards everything; no partial state survives.
// CONFIGURATION
//  - PIPE_SKID_STATS_EN defined: stall_cnt and flush_cnt ports exist.
//  - Each counter increments by 1 per qualifying cycle and saturates at all-ones.
//  - Each counter clears only on reset.
//  - PIPE_SKID_STATS_EN undefined: counter ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - Package pipe_pkg holds typedef enum logic [1:0] pipe_state_e {PS_EMPTY=0, PS_ONE=1, PS_FULL=2}.
//  - pipe_pkg also holds localparam PIPE_CNT_W_DEFAULT = 32.
//  - Sub-module pipe_skid_entry (x2: main, skid) holds one {ctrl,data} register with load, clear_ctrl and reset.
//  - The top level holds the FSM, the ready/valid logic and the optional counters.
// TESTING
//  - Reset: rst_n=0 for 2 cycles with in_valid=1, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, in_ready=1 after release.
//  - Streaming: out_ready=1, push ctrl 1..8 / data 0xA0..0xA7 back-to-back.
//    -> out_valid each cycle from cycle+1, same order, no gaps.
//  - Back-pressure: out_ready=0, push ctrl 5, 6 -> in_ready=0 after 2nd push; out_ctrl=5 held.
//    Then out_ready=1 -> 5 then 6 delivered, in_ready=1 again.
//  - Flush in FULL: entries ctrl 3, 4 held, data 0x33, 0x44; flush=1 with in_valid=1 ctrl 9.
//    -> next cycle out_valid=0, out_ctrl=0, data reg still 0x33, ctrl 9 never appears.
//  - Reset vs flush: rst_n=0 & flush=1 together -> reset values, data=0.
//  - Stats (PIPE_SKID_STATS_EN): out_ready=0 for 10 valid cycles, 3 flush cycles -> stall_cnt=10, flush_cnt=3.
//    With CNT_W=4 and 20 stall cycles -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline-stage register.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_FULL  = 2'd2
   } pipe_state_e;

   localparam int unsigned PIPE_CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipe_skid_entry.sv
// One {ctrl,data} holding register; clearing kills ctrl only and leaves data untouched.
module pipe_skid_entry #(
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              clr_ctrl_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         data_q <= '0;
      end else begin
         if (clr_ctrl_i) begin
            ctrl_q <= '0;
         end else if (load_i) begin
            ctrl_q <= ctrl_i;
         end
         if (load_i && !clr_ctrl_i) begin
            data_q <= data_i;
         end
      end
   end

   assign ctrl_o = ctrl_q;
   assign data_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and valid/ready flow control.
// Optional saturating stall/flush counters are built when PIPE_SKID_STATS_EN is defined.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned DATA_W = 128
`ifdef PIPE_SKID_STATS_EN
   ,
   parameter int unsigned CNT_W  = PIPE_CNT_W_DEFAULT
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   pipe_state_e       state_q, state_d;
   logic              in_fire, out_fire;
   logic              main_load, main_from_skid, skid_load, clr_ctrl;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
   logic [DATA_W-1:0] main_data, skid_data, main_data_in;

   assign in_ready  = (state_q != PS_FULL) && !flush;
   assign out_valid = (state_q != PS_EMPTY);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= PS_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush overrides the handshake; a head consumed under flush needs no extra action.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      clr_ctrl       = 1'b0;
      if (flush) begin
         state_d  = PS_EMPTY;
         clr_ctrl = 1'b1;
      end else begin
         unique case (state_q)
            PS_EMPTY: begin
               if (in_fire) begin
                  main_load = 1'b1;
                  state_d   = PS_ONE;
               end
            end
            PS_ONE: begin
               if (out_fire && in_fire) begin
                  main_load = 1'b1;
               end else if (out_fire) begin
                  state_d = PS_EMPTY;
               end else if (in_fire) begin
                  skid_load = 1'b1;
                  state_d   = PS_FULL;
               end
            end
            PS_FULL: begin
               if (out_fire) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = PS_ONE;
               end
            end
            default: state_d = PS_EMPTY;
         endcase
      end
   end

   assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_data_in = main_from_skid ? skid_data : in_data;

   pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (main_load),
      .clr_ctrl_i (clr_ctrl),
      .ctrl_i     (main_ctrl_in),
      .data_i     (main_data_in),
      .ctrl_o     (main_ctrl),
      .data_o     (main_data)
   );

   pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (skid_load),
      .clr_ctrl_i (clr_ctrl),
      .ctrl_i     (in_ctrl),
      .data_i     (in_data),
      .ctrl_o     (skid_ctrl),
      .data_o     (skid_data)
   );

   assign out_ctrl = out_valid ? main_ctrl : '0;
   assign out_data = main_data;

`ifdef PIPE_SKID_STATS_EN
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   // Saturating event counters, cleared only by reset.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
      if (flush && (flush_q != '1)) begin
         flush_d = flush_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, hand sequences and a random run against a queue model.
module tb_pipe_skid_stage;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [15:0]  in_ctrl, out_ctrl;
   logic [127:0] in_data, out_data;
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

`ifdef PIPE_SKID_STATS_EN
   logic [31:0]  stall_cnt, flush_cnt;
   logic         s_in_ready, s_out_valid;
   logic [15:0]  s_out_ctrl;
   logic [127:0] s_out_data;
   logic [3:0]   s_stall_cnt, s_flush_cnt;

   pipe_skid_stage #(.CTRL_W(16), .DATA_W(128), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_ctrl(s_out_ctrl), .out_data(s_out_data), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );
`endif

   pipe_skid_stage #(.CTRL_W(16), .DATA_W(128)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_SKID_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   typedef struct {
      logic         rst_n, flush, in_valid;
      logic [15:0]  in_ctrl;
      logic [127:0] in_data;
      logic         out_ready;
      logic         chk, chk_data, exp_ov;
      logic [15:0]  exp_oc;
      logic         exp_ir;
      logic [127:0] exp_od;
   } vec_t;

   typedef struct {
      logic [15:0]  ctrl;
      logic [127:0] data;
   } entry_t;

   vec_t   vecs[18];
   entry_t q[$];

   function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [15:0] ic,
                               input logic [127:0] id, input logic ordy, input logic c, input logic cd,
                               input logic eov, input logic [15:0] eoc, input logic eir,
                               input logic [127:0] eod);
      vec_t v;
      v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_ctrl = ic; v.in_data = id;
      v.out_ready = ordy; v.chk = c; v.chk_data = cd; v.exp_ov = eov; v.exp_oc = eoc;
      v.exp_ir = eir; v.exp_od = eod;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv, input logic [15:0] ic,
                        input logic [127:0] id, input logic ordy);
      rst_n = r; flush = f; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] rd;
      logic         r, f, iv, ordy, exp_ir, exp_ov;
      logic [15:0]  rc, exp_oc;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;

      //   rst flush iv ctrl data   ordy chk chkd ov oc ir od
      vecs[0]  = mk(0, 0, 1, 16'hFFFF, 128'h0,    0, 0, 0, 0, 16'h0, 1, 128'h0);
      vecs[1]  = mk(0, 0, 1, 16'hFFFF, 128'h0,    0, 1, 1, 0, 16'h0, 1, 128'h0);
      vecs[2]  = mk(1, 0, 0, 16'h0,    128'h0,    0, 1, 1, 0, 16'h0, 1, 128'h0);
      vecs[3]  = mk(1, 0, 1, 16'h5,    128'h55,   0, 1, 0, 0, 16'h0, 1, 128'h0);
      vecs[4]  = mk(1, 0, 1, 16'h6,    128'h66,   0, 1, 1, 1, 16'h5, 1, 128'h55);
      vecs[5]  = mk(1, 0, 1, 16'h7,    128'h77,   0, 1, 1, 1, 16'h5, 0, 128'h55);
      vecs[6]  = mk(1, 0, 0, 16'h0,    128'h0,    1, 1, 1, 1, 16'h5, 0, 128'h55);
      vecs[7]  = mk(1, 0, 0, 16'h0,    128'h0,    1, 1, 1, 1, 16'h6, 1, 128'h66);
      vecs[8]  = mk(1, 0, 0, 16'h0,    128'h0,    1, 1, 0, 0, 16'h0, 1, 128'h0);
      vecs[9]  = mk(1, 0, 1, 16'h3,    128'h33,   0, 1, 0, 0, 16'h0, 1, 128'h0);
      vecs[10] = mk(1, 0, 1, 16'h4,    128'h44,   0, 1, 1, 1, 16'h3, 1, 128'h33);
      vecs[11] = mk(1, 1, 1, 16'h9,    128'h99,   1, 1, 1, 1, 16'h3, 0, 128'h33);
      vecs[12] = mk(1, 0, 0, 16'h0,    128'h0,    1, 1, 1, 0, 16'h0, 1, 128'h33);
      vecs[13] = mk(1, 1, 1, 16'hA,    128'hAA,   1, 1, 1, 0, 16'h0, 0, 128'h33);
      vecs[14] = mk(1, 0, 0, 16'h0,    128'h0,    1, 1, 1, 0, 16'h0, 1, 128'h33);
      vecs[15] = mk(1, 0, 1, 16'h11,   128'h1111, 0, 1, 0, 0, 16'h0, 1, 128'h0);
      vecs[16] = mk(0, 1, 1, 16'h22,   128'h2222, 0, 1, 1, 1, 16'h11, 0, 128'h1111);
      vecs[17] = mk(1, 0, 0, 16'h0,    128'h0,    0, 1, 1, 0, 16'h0, 1, 128'h0);

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].in_ctrl,
               vecs[i].in_data, vecs[i].out_ready);
         if (vecs[i].chk) begin
            check($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
            check($sformatf("vec%0d out_ctrl", i), 128'(out_ctrl), 128'(vecs[i].exp_oc));
            check($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(vecs[i].exp_ir));
            if (vecs[i].chk_data) begin
               check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_od);
            end
         end
         tick();
      end

      // Back-to-back streaming with out_ready held high.
      for (int k = 0; k < 10; k++) begin
         if (k < 8) drive(1, 0, 1, 16'(k + 1), 128'(8'hA0 + k), 1);
         else       drive(1, 0, 0, 16'h0, 128'h0, 1);
         check($sformatf("stream%0d in_ready", k), 128'(in_ready), 128'(1));
         check($sformatf("stream%0d out_valid", k), 128'(out_valid), 128'((k >= 1 && k <= 8) ? 1 : 0));
         if (k >= 1 && k <= 8) begin
            check($sformatf("stream%0d out_ctrl", k), 128'(out_ctrl), 128'(k));
            check($sformatf("stream%0d out_data", k), out_data, 128'(8'hA0 + k - 1));
         end
         tick();
      end

`ifdef PIPE_SKID_STATS_EN
      drive(0, 0, 0, 16'h0, 128'h0, 0); tick();
      drive(1, 0, 1, 16'h1, 128'h1, 0); tick();
      for (int k = 0; k < 10; k++) begin drive(1, 0, 0, 16'h0, 128'h0, 0); tick(); end
      drive(1, 0, 0, 16'h0, 128'h0, 1); tick();
      for (int k = 0; k < 3; k++) begin drive(1, 1, 0, 16'h0, 128'h0, 0); tick(); end
      drive(1, 0, 0, 16'h0, 128'h0, 0);
      check("stats stall_cnt", 128'(stall_cnt), 128'(10));
      check("stats flush_cnt", 128'(flush_cnt), 128'(3));
      check("stats sat stall_cnt 10", 128'(s_stall_cnt), 128'(10));
      drive(1, 0, 1, 16'h2, 128'h2, 0); tick();
      for (int k = 0; k < 10; k++) begin drive(1, 0, 0, 16'h0, 128'h0, 0); tick(); end
      check("stats stall_cnt 20", 128'(stall_cnt), 128'(20));
      check("stats sat stall_cnt", 128'(s_stall_cnt), 128'(15));
      check("stats sat flush_cnt", 128'(s_flush_cnt), 128'(3));
`endif

      // Random traffic against a bounded FIFO model; cycle 0 resets both sides into sync.
      for (int c = 0; c < 3000; c++) begin
         r    = (c == 0) ? 1'b0 : ($urandom_range(99) != 0);
         f    = ($urandom_range(19) == 0);
         iv   = 1'($urandom_range(1));
         ordy = ($urandom_range(3) != 0);
         rc   = 16'($urandom);
         rd   = {$urandom, $urandom, $urandom, $urandom};
         drive(r, f, iv, rc, rd, ordy);
         exp_ir = (q.size() < 2) && !f;
         exp_ov = (q.size() > 0);
         exp_oc = exp_ov ? q[0].ctrl : 16'h0;
         if (c > 0) begin
            check("rand in_ready", 128'(in_ready), 128'(exp_ir));
            check("rand out_valid", 128'(out_valid), 128'(exp_ov));
            check("rand out_ctrl", 128'(out_ctrl), 128'(exp_oc));
            if (exp_ov) check("rand out_data", out_data, q[0].data);
         end
         if (!r || f) begin
            q.delete();
         end else begin
            if (exp_ov && ordy) void'(q.pop_front());
            if (iv && exp_ir) begin
               entry_t e;
               e.ctrl = rc;
               e.data = rd;
               q.push_back(e);
            end
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
